// File: rtl/latch_word_assembler_pkg.sv
// Shared types and helpers for the latch word assembler.
// Output slot states and the bit counter width function.
package latch_asm_pkg;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/latch_word_assembler_if.sv
// Bus bundle between the upstream D latch / downstream consumer and the assembler.
// The slave modport is the assembler side; the master modport is the environment side.
interface latch_word_assembler_if
    import latch_asm_pkg::*;
#(
    parameter int WIDTH = 8
);

    logic                       latch_q;
    logic                       latch_en;
    logic                       out_ready;
    logic [WIDTH-1:0]           word_out;
    logic                       word_valid;
    logic                       overrun;
    logic [cnt_w(WIDTH)-1:0]    bit_count;

    modport slave (
        input  latch_q,
        input  latch_en,
        input  out_ready,
        output word_out,
        output word_valid,
        output overrun,
        output bit_count
    );

    modport master (
        output latch_q,
        output latch_en,
        output out_ready,
        input  word_out,
        input  word_valid,
        input  overrun,
        input  bit_count
    );

endinterface

// File: rtl/latch_word_assembler_sync.sv
// Synchronizers for latch_q / latch_en plus falling-edge detect on the synchronized enable.
// d_s and the enable are sampled on the same clk edge, so d_s is the captured bit when fall is high.
module sync_fall_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    input  logic en_in,
    output logic d_s,
    output logic fall
);

    logic [SYNC_STAGES-1:0] d_sync;
    logic [SYNC_STAGES-1:0] en_sync;
    logic                   en_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_sync  <= '0;
            en_sync <= '0;
            en_d    <= 1'b0;
        end else begin
            d_sync  <= {d_sync[SYNC_STAGES-2:0], d_in};
            en_sync <= {en_sync[SYNC_STAGES-2:0], en_in};
            en_d    <= en_sync[SYNC_STAGES-1];
        end
    end

    assign d_s  = d_sync[SYNC_STAGES-1];
    assign fall = en_d & ~en_sync[SYNC_STAGES-1];

endmodule

// File: rtl/latch_word_assembler.sv
// Packs one bit per closing of an upstream D latch into WIDTH-bit words,
// presented through a single valid/ready output slot with a sticky overrun flag.
module latch_word_assembler
    import latch_asm_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    latch_word_assembler_if.slave  bus
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic              q_s;
    logic              cap;
    logic              complete;
    logic [WIDTH-1:0]  shift_reg;
    logic [WIDTH-1:0]  shift_nxt;
    logic [CW-1:0]     bit_count_q;
    logic [WIDTH-1:0]  word_q;
    logic              overrun_q;
    logic              load_word;
    logic              set_overrun;
    slot_state_t       state_q;
    slot_state_t       state_nxt;

    sync_fall_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .d_in  (bus.latch_q),
        .en_in (bus.latch_en),
        .d_s   (q_s),
        .fall  (cap)
    );

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shift_nxt = {shift_reg[WIDTH-2:0], q_s};
        end else begin : g_lsb_first
            assign shift_nxt = {q_s, shift_reg[WIDTH-1:1]};
        end
    endgenerate

    assign complete = cap && (bit_count_q == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_nxt;
        end
    end

    // A completion while the slot is full only lands if the held word leaves this cycle.
    always_comb begin
        state_nxt   = state_q;
        load_word   = 1'b0;
        set_overrun = 1'b0;
        case (state_q)
            SLOT_EMPTY: begin
                if (complete) begin
                    state_nxt = SLOT_FULL;
                    load_word = 1'b1;
                end
            end
            SLOT_FULL: begin
                if (bus.out_ready) begin
                    if (complete) begin
                        load_word = 1'b1;
                    end else begin
                        state_nxt = SLOT_EMPTY;
                    end
                end else if (complete) begin
                    set_overrun = 1'b1;
                end
            end
            default: begin
                state_nxt = SLOT_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg   <= '0;
            bit_count_q <= '0;
            word_q      <= '0;
            overrun_q   <= 1'b0;
        end else begin
            if (cap) begin
                if (complete) begin
                    shift_reg   <= '0;
                    bit_count_q <= '0;
                end else begin
                    shift_reg   <= shift_nxt;
                    bit_count_q <= bit_count_q + 1'b1;
                end
            end
            if (load_word) begin
                word_q <= shift_nxt;
            end
            if (set_overrun) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = (state_q == SLOT_FULL);
    assign bus.overrun    = overrun_q;
    assign bus.bit_count  = bit_count_q;

endmodule

// File: tb/tb_latch_word_assembler.sv
// Bench for latch_word_assembler: an MSB-first and an LSB-first instance share one latch stimulus.
module tb_latch_word_assembler;

    logic clk = 1'b0;
    logic rst;
    logic latch_q;
    logic latch_en;
    logic out_ready;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    latch_word_assembler_if #(.WIDTH(8)) if_m ();
    latch_word_assembler_if #(.WIDTH(8)) if_l ();

    assign if_m.latch_q   = latch_q;
    assign if_m.latch_en  = latch_en;
    assign if_m.out_ready = out_ready;
    assign if_l.latch_q   = latch_q;
    assign if_l.latch_en  = latch_en;
    assign if_l.out_ready = out_ready;

    latch_word_assembler #(.WIDTH(8), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (if_m.slave)
    );

    latch_word_assembler #(.WIDTH(8), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (if_l.slave)
    );

    typedef struct {
        logic [7:0] bits;   // bits[7] is sent first
        logic [7:0] exp_m;
        logic [7:0] exp_l;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        latch_q  = b;
        latch_en = 1'b1;
        repeat (8) @(negedge clk);
        latch_en = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic chk_reset_state();
        chk("rst_valid_m", 32'(if_m.word_valid), 0);
        chk("rst_word_m",  32'(if_m.word_out),   0);
        chk("rst_ovr_m",   32'(if_m.overrun),    0);
        chk("rst_cnt_m",   32'(if_m.bit_count),  0);
        chk("rst_valid_l", 32'(if_l.word_valid), 0);
        chk("rst_word_l",  32'(if_l.word_out),   0);
        chk("rst_cnt_l",   32'(if_l.bit_count),  0);
    endtask

    // Sends 8 bits; during the final low phase records when word_valid rises,
    // how many cycles it stays high and the word seen while it is high.
    task automatic send_word(input logic [7:0] w, input bit chk_cnt,
                             output int lat_m, output int lat_l,
                             output int hi_m, output int seen_m, output int seen_l);
        logic prev_m, prev_l;
        lat_m = -1; lat_l = -1; hi_m = 0; seen_m = -1; seen_l = -1;
        for (int i = 7; i >= 1; i--) begin
            send_bit(w[i]);
            if (chk_cnt) begin
                chk("cnt_step_m", 32'(if_m.bit_count), 32'(8 - i));
                chk("cnt_step_l", 32'(if_l.bit_count), 32'(8 - i));
            end
        end
        @(negedge clk);
        latch_q  = w[0];
        latch_en = 1'b1;
        repeat (8) @(negedge clk);
        latch_en = 1'b0;
        prev_m = if_m.word_valid;
        prev_l = if_l.word_valid;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (lat_m < 0 && if_m.word_valid && !prev_m) lat_m = k;
            if (lat_l < 0 && if_l.word_valid && !prev_l) lat_l = k;
            if (if_m.word_valid) hi_m++;
            if (seen_m < 0 && if_m.word_valid) seen_m = int'(if_m.word_out);
            if (seen_l < 0 && if_l.word_valid) seen_l = int'(if_l.word_out);
            prev_m = if_m.word_valid;
            prev_l = if_l.word_valid;
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_m, lat_l, hi_m, seen_m, seen_l;
        logic [7:0] w;

        vecs[0] = '{bits: 8'hB2, exp_m: 8'hB2, exp_l: 8'h4D};
        vecs[1] = '{bits: 8'h5A, exp_m: 8'h5A, exp_l: 8'h5A};
        vecs[2] = '{bits: 8'h01, exp_m: 8'h01, exp_l: 8'h80};
        vecs[3] = '{bits: 8'hF0, exp_m: 8'hF0, exp_l: 8'h0F};
        vecs[4] = '{bits: 8'h96, exp_m: 8'h96, exp_l: 8'h69};
        vecs[5] = '{bits: 8'hFF, exp_m: 8'hFF, exp_l: 8'hFF};

        rst       = 1'b1;
        latch_q   = 1'b0;
        latch_en  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state();
        rst = 1'b0;

        // Streaming words with the consumer always ready
        out_ready = 1'b1;
        foreach (vecs[v]) begin
            send_word(vecs[v].bits, (v < 2), lat_m, lat_l, hi_m, seen_m, seen_l);
            chk("lat_m",   32'(lat_m),  3);
            chk("lat_l",   32'(lat_l),  3);
            chk("pulse_m", 32'(hi_m),   1);
            chk("word_m",  32'(seen_m), 32'(vecs[v].exp_m));
            chk("word_l",  32'(seen_l), 32'(vecs[v].exp_l));
            chk("idle_valid_m", 32'(if_m.word_valid), 0);
            chk("wrap_cnt_l",   32'(if_l.bit_count),  0);
            chk("no_ovr_m",     32'(if_m.overrun),    0);
        end

        // Overrun: second word dropped while the first is held
        out_ready = 1'b0;
        send_word(8'hB2, 1'b0, lat_m, lat_l, hi_m, seen_m, seen_l);
        chk("hold_valid_m", 32'(if_m.word_valid), 1);
        send_word(8'h5A, 1'b0, lat_m, lat_l, hi_m, seen_m, seen_l);
        chk("ovr_word_m",  32'(if_m.word_out),   32'h B2);
        chk("ovr_word_l",  32'(if_l.word_out),   32'h 4D);
        chk("ovr_flag_m",  32'(if_m.overrun),    1);
        chk("ovr_flag_l",  32'(if_l.overrun),    1);
        chk("ovr_valid_m", 32'(if_m.word_valid), 1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drain_valid_m", 32'(if_m.word_valid), 0);
        chk("drain_word_m",  32'(if_m.word_out),   32'h B2);
        chk("ovr_sticky_m",  32'(if_m.overrun),    1);
        repeat (4) @(posedge clk);
        #1;
        chk("ovr_sticky2_m", 32'(if_m.overrun),    1);
        chk("drain_once_m",  32'(if_m.word_valid), 0);
        pulse_reset();
        chk_reset_state();

        // Completion coinciding with the transfer of the held word
        out_ready = 1'b0;
        send_word(8'hB2, 1'b0, lat_m, lat_l, hi_m, seen_m, seen_l);
        w = 8'h5A;
        for (int i = 7; i >= 1; i--) send_bit(w[i]);
        @(negedge clk);
        latch_q  = w[0];
        latch_en = 1'b1;
        repeat (8) @(negedge clk);
        latch_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("pre_valid_m", 32'(if_m.word_valid), 1);
        chk("pre_word_m",  32'(if_m.word_out),   32'h B2);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bb_valid_m", 32'(if_m.word_valid), 1);
        chk("bb_word_m",  32'(if_m.word_out),   32'h 5A);
        chk("bb_word_l",  32'(if_l.word_out),   32'h 5A);
        chk("bb_ovr_m",   32'(if_m.overrun),    0);
        chk("bb_ovr_l",   32'(if_l.overrun),    0);
        @(posedge clk);
        #1;
        chk("bb_done_m", 32'(if_m.word_valid), 0);
        repeat (6) @(negedge clk);

        // Reset in the middle of a word
        repeat (5) send_bit(1'b1);
        chk("part_cnt_m", 32'(if_m.bit_count), 5);
        chk("part_cnt_l", 32'(if_l.bit_count), 5);
        pulse_reset();
        chk_reset_state();
        send_word(8'h0F, 1'b0, lat_m, lat_l, hi_m, seen_m, seen_l);
        chk("clean_lat_m",  32'(lat_m),  3);
        chk("clean_word_m", 32'(seen_m), 32'h 0F);
        chk("clean_word_l", 32'(seen_l), 32'h F0);

        // latch_q wiggles while the latch is transparent; only the closing value counts
        out_ready = 1'b0;
        @(negedge clk);
        latch_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            latch_q = ~latch_q;
        end
        @(negedge clk);
        latch_q = 1'b1;
        repeat (4) @(negedge clk);
        latch_en = 1'b0;
        repeat (8) @(negedge clk);
        chk("glitch_cnt_m", 32'(if_m.bit_count), 1);
        chk("glitch_cnt_l", 32'(if_l.bit_count), 1);
        repeat (7) send_bit(1'b0);
        chk("glitch_valid_m", 32'(if_m.word_valid), 1);
        chk("glitch_word_m",  32'(if_m.word_out),   32'h 80);
        chk("glitch_word_l",  32'(if_l.word_out),   32'h 01);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("glitch_drain_m", 32'(if_m.word_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
